// File: rtl/muldiv_seq_ctrl.sv
// HI/LO op sequencer: latches operands, handshakes the iterative divider, times the multiplier.
// Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses the divider with a fixed result.
module muldiv_seq_ctrl #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        stallM,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] mul_result,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        timeout_err
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_TIMEOUT);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   result;
  logic          accept, is_div, fast_zero, abort, div_to, launch;

  assign accept = (state == IDLE) && op_valid && !flushE;
  assign is_div = op_code[1];
`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = is_div && (src_b == 32'd0);
`else
  assign fast_zero = 1'b0;
`endif
  assign launch = accept && is_div && !fast_zero;

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    div_to   = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = !is_div ? MUL : (fast_zero ? DONE : DIV);
      MUL: begin
        if (flushE)              state_nx = IDLE;
        else if (cnt == MUL_END) state_nx = DONE;
      end
      DIV: begin
        if (flushE) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (div_ready) begin
          state_nx = DONE;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          abort    = 1'b1;
          div_to   = 1'b1;
        end
      end
      DONE: if (flushE || !stallM) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign stall_o    = accept || (state == MUL) || (state == DIV);
  assign hilo_we    = (state == DONE) && !flushE;
  assign hilo_wdata = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      div_annul   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      // Start/annul are registered so the divider sees latched operands with the pulse.
      div_start   <= launch;
      div_signed  <= launch && (op_code == 2'b10);
      div_annul   <= abort;
      timeout_err <= timeout_err | div_to;
      if (accept) begin
        op_a <= src_a;
        op_b <= src_b;
        cnt  <= '0;
      end else if (((state == MUL) || (state == DIV)) && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (accept && fast_zero)
        result <= {src_a, 32'hFFFF_FFFF};
      else if ((state == MUL) && (cnt == MUL_END) && !flushE)
        result <= mul_result;
      else if ((state == DIV) && div_ready && !flushE)
        result <= div_result;
    end
  end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Randomized scoreboard bench for muldiv_seq_ctrl with behavioural multiplier/divider models.
module tb_muldiv_seq_ctrl;
  localparam int MUL_LAT = 2;
  localparam int DIV_TIMEOUT = 48;

  logic        clk = 1'b0, rst = 1'b1;
  logic        flushE = 0, stallM = 0, op_valid = 0;
  logic [1:0]  op_code = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic [63:0] mul_result, div_result;
  logic        div_ready;
  logic        div_start, div_signed, div_annul, stall_o, hilo_we, timeout_err;
  logic [31:0] op_a, op_b;
  logic [63:0] hilo_wdata;

  muldiv_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .stallM(stallM), .op_valid(op_valid),
    .op_code(op_code), .src_a(src_a), .src_b(src_b), .mul_result(mul_result),
    .div_ready(div_ready), .div_result(div_result), .div_start(div_start),
    .div_signed(div_signed), .div_annul(div_annul), .op_a(op_a), .op_b(op_b),
    .stall_o(stall_o), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural HI/LO result of an op: {hi,lo}; divide-by-zero returns {a, all ones}.
  function automatic logic [63:0] ref_res(input logic [1:0] code, input logic [31:0] a, b);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (code)
      2'b00: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp; end
      2'b01: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (code == 2'b10) begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          return {sr, sq};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Multiplier model: combinational product of the latched operands.
  logic cur_sgn = 0;
  assign mul_result = ref_res(cur_sgn ? 2'b00 : 2'b01, op_a, op_b);

  // Divider model: responds div_lat cycles after start; 0 means never; annul cancels.
  int div_lat = 1;
  initial begin
    int dcnt;
    logic [63:0] dres;
    dcnt = 0; dres = 0;
    div_ready = 0; div_result = 0;
    forever begin
      @(negedge clk);
      div_ready = 0;
      if (div_annul) dcnt = 0;
      if (div_start && div_lat > 0) begin
        dcnt = div_lat;
        dres = ref_res({1'b1, ~div_signed}, op_a, op_b);
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_ready  = 1;
          div_result = dres;
        end
      end
    end
  end

  // Monitor: every commit (write with no downstream stall) must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_start && div_annul) chk("start_annul_overlap", 1, 0);
      if (hilo_we && !stallM) begin
        if (exp_q.size() == 0) chk("unexpected_write", hilo_wdata, 0);
        else chk("hilo_wdata", hilo_wdata, exp_q.pop_front());
      end
    end
  end

  int last_stall, last_annul, last_start;

  task automatic run_op(input logic [1:0] code, input logic [31:0] a, b,
                        input int lat, input int flush_k, input int hold);
    bit fast, exp_write, done, commit;
    int we_cnt, first_we, i;
`ifdef DIV_ZERO_FAST_EN
    fast = code[1] && (b == 0);
`else
    fast = 0;
`endif
    exp_write = (flush_k < 0) && (lat > 0 || fast || !code[1]);
    div_lat = lat;
    if (exp_write) exp_q.push_back(ref_res(code, a, b));
    last_stall = 0; last_annul = 0; last_start = 0;
    we_cnt = 0; first_we = -1; done = 0; commit = 0;
    for (i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      op_valid = (i == 0);
      flushE   = (i == flush_k);
      if (i == 0) begin
        op_code = code; src_a = a; src_b = b; cur_sgn = (code == 2'b00);
      end
      if (flush_k >= 0) stallM = 1;
      else if (hilo_we) stallM = (we_cnt < hold);
      else stallM = 1'($urandom_range(1));
      @(negedge clk);
      if (stall_o) last_stall++;
      if (div_annul) last_annul++;
      if (div_start) begin
        last_start++;
        chk("div_signed", div_signed, code == 2'b10);
      end
      if (i == flush_k) chk("we_on_flush", hilo_we, 0);
      if (hilo_we) begin
        if (first_we < 0) first_we = i;
        we_cnt++;
        if (!stallM) commit = 1;
      end
      if (exp_write) done = commit;
      else if (flush_k >= 0) done = (i > flush_k) && !stall_o;
      else done = div_annul;
    end
    op_valid = 0; flushE = 0; stallM = 0;
    if (!done) chk("op_timeout", 0, 1);
    chk("div_start_count", last_start, (code[1] && !fast) ? 1 : 0);
    if (!code[1]) chk("annul_on_mul", last_annul, 0);
    chk("commit_seen", commit, exp_write);
    if (exp_write) begin
      chk("we_hold_cycles", we_cnt, hold + 1);
      if (!code[1]) chk("mul_latency", first_we, MUL_LAT + 1);
      if (fast) chk("fast_latency", first_we, 1);
    end
  endtask

  initial begin
    logic [1:0] c;
    logic [31:0] a, b;
    int lat, fk;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {div_start, div_signed, div_annul, op_a, op_b, stall_o, hilo_we,
                          hilo_wdata, timeout_err}, 0);
    @(posedge clk); #1 rst = 0;

    // MULTU max*2: three stall cycles, single write.
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1, -1, 0);
    chk("t1_stall_cycles", last_stall, 3);
    chk("t1_ref", ref_res(2'b01, 32'hFFFF_FFFF, 32'd2), 64'h1_FFFF_FFFE);
    // DIV -7/2 with a long divider latency.
    run_op(2'b10, -32'sd7, 32'd2, 33, -1, 0);
    chk("t2_ref", ref_res(2'b10, -32'sd7, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // DIVU flushed mid-flight.
    run_op(2'b11, 32'd1000, 32'd7, 30, 10, 0);
    chk("t3_annul", last_annul, 1);
    // Result held under downstream stall for 3 cycles.
    run_op(2'b00, 32'hFFFF_FFF0, 32'd3, 1, -1, 3);
    // Divider never answers.
    chk("t5_err_before", timeout_err, 0);
    run_op(2'b11, 32'd9, 32'd3, 0, -1, 0);
    chk("t5_annul", last_annul, 1);
    chk("t5_timeout_err", timeout_err, 1);
    // Divide by zero.
    run_op(2'b11, 32'd5, 32'd0, 5, -1, 0);
    chk("t6_ref", ref_res(2'b11, 32'd5, 32'd0), 64'h5_FFFF_FFFF);

    for (int n = 0; n < 80; n++) begin
      c = 2'($urandom_range(3));
      a = $urandom;
      b = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      lat = $urandom_range(40, 1);
      fk = -1;
      if ($urandom_range(4) == 0) fk = $urandom_range(c[1] ? lat + 3 : 4, 1);
      run_op(c, a, b, lat, fk, $urandom_range(3));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
